seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential signed restoring divider; the inverse datapath of the shift-add multiplier.
- Takes a 2W-bit signed dividend (typically a product) and a W-bit signed divisor; returns a W-bit signed quotient and a W-bit signed remainder.
- Works in sign-magnitude form, one quotient bit per clock, with a start/done handshake matching the multiplier's.
- Sits beside the multiplier in the arithmetic unit.

Parameters:
- WIDTH, 8: width of divisor, quotient and remainder. The dividend is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  2*WIDTH  signed two's-complement dividend; sampled on the start edge.
- divisor  input  WIDTH  signed two's-complement divisor; sampled on the start edge.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows the dividend.
- done  output  1  one-cycle pulse when quotient/remainder/err are valid.
- busy  output  1  high from the accepted start until the done pulse (inclusive).
- sign  output  1  dividend[MSB] XOR divisor[MSB] of the accepted operation.
- err  output  1  divide-by-zero or quotient overflow; valid with done.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - quotient, remainder, done, busy, sign, err all 0.
  - Internal registers cleared.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE -> DIV -> FIX -> IDLE.
- IDLE:
  - On an edge with start=1 (edge E0), latch |dividend| (2W+1 bits), |divisor| (W+1 bits, so -2^(W-1) is held correctly), sign, dividend sign, and divisor==0. Set busy=1 and count=0.
  - If divisor==0, go to FIX. Otherwise go to DIV.
- DIV:
  - Each edge: shift the partial remainder left, bringing in the next dividend MSB.
  - If the partial remainder >= |divisor|, subtract and set the quotient bit to 1; else set it to 0.
  - 2W iterations on E1..E2W. count wraps to 0 at 2W-1 -> FIX.
- FIX, one edge:
  - Overflow if the magnitude quotient exceeds 2^(W-1)-1 (sign=0) or 2^(W-1) (sign=1).
  - On divide-by-zero or overflow: err=1; quotient and remainder per the Optional Feature.
  - Otherwise: quotient = sign ? -Qmag : Qmag; remainder = dividend-negative ? -Rmag : Rmag (|R| < |divisor| always fits W bits); err=0.
  - done=1, busy stays 1 for this cycle, then state=IDLE.
- Latency:
  - Normal operation: done is high in the cycle after edge E(2W+1), i.e. 2W+1 clocks after the start edge (17 for W=8).
  - Divide-by-zero: done after E1.
- done is a single-cycle pulse. quotient, remainder, sign and err hold their values until the next done or a reset.
- start while busy=1 is ignored; operands are not re-sampled.
- start held high continuously: a new operation is accepted on the first IDLE edge after done, giving back-to-back operations.
- Changing the operand inputs while busy has no effect.

Optional Feature:
- Macro: DIVIDER_SATURATE_EN.
- Defined:
  - Overflow gives quotient = 2^(W-1)-1 (sign=0) or -2^(W-1) (sign=1), remainder=0.
  - Divide-by-zero gives quotient saturated by the dividend sign (0x7F or 0x80 for W=8), remainder=0.
  - err=1 in both cases.
- Undefined: quotient=0 and remainder=0 on any error; err=1.

Test Plan:
- 100 / 7 -> quotient=14 (0x0E), remainder=2, sign=0, err=0; done pulses exactly 17 clocks after the start edge, one cycle wide; busy high throughout.
- -100 / 7 -> quotient=-14 (0xF2), remainder=-2 (0xFE), sign=1. Also -100 / -7 -> quotient=14, remainder=-2, sign=0.
- Range edges:
  - -16384 / 128 is not tested (divisor limited to -128..127).
  - -16384 / -128 -> quotient 128 overflows: err=1, quotient=0 (0x7F with DIVIDER_SATURATE_EN).
  - 16256 / -128 -> quotient=-127 (0x81), remainder=0, err=0.
  - -16384 / 127 -> magnitude 129 overflows: err=1.
- 500 / 0 -> err=1, done one clock after start, quotient=0, remainder=0 (0x7F/0 with the macro).
- Hold start high for 3 operations, changing operands right after each done -> three results, done pulses 18 clocks apart. A start pulse mid-operation is ignored.
- Start 100 / 7, drop rst_n at iteration 5 -> all outputs 0 immediately, no done pulse. After release, start 1000 / 3 -> err=1 (overflow, magnitude 333).

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: sequential signed restoring divider, one quotient bit per clock.
//
// Divides a 2*WIDTH-bit signed dividend by a WIDTH-bit signed divisor in
// sign-magnitude form. The quotient is truncated toward zero. The remainder
// takes the sign of the dividend.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset; aborts any operation in flight
//   start_i      request a division (only sampled while idle)
//   dividend_i   2*WIDTH-bit signed dividend, sampled on the accepted start edge
//   divisor_i    WIDTH-bit signed divisor, sampled on the accepted start edge
//   quotient_o   signed quotient; holds until the next done
//   remainder_o  signed remainder; holds until the next done
//   done_o       one-cycle pulse when the results are valid
//   busy_o       high from the accepted start through the done cycle
//   sign_o       dividend MSB xor divisor MSB of the completed operation
//   err_o        divide-by-zero or quotient overflow, valid with done
//
// Build option: define DIVIDER_SATURATE_EN to saturate the quotient on errors
// instead of returning zero.

module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [2*WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [WIDTH-1:0]   quotient_o,
  output logic [WIDTH-1:0]   remainder_o,
  output logic               done_o,
  output logic               busy_o,
  output logic               sign_o,
  output logic               err_o
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(DW);
  localparam logic [CW-1:0] LastCnt = CW'(DW - 1);
  localparam logic [DW-1:0] QMaxPos = DW'((2 ** (WIDTH - 1)) - 1);
  localparam logic [DW-1:0] QMaxNeg = DW'(2 ** (WIDTH - 1));
`ifdef DIVIDER_SATURATE_EN
  localparam logic [WIDTH-1:0] SatPos = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] SatNeg = {1'b1, {(WIDTH - 1){1'b0}}};
`endif

  typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // dq_q starts as |dividend| and shifts out dividend bits while shifting in
  // quotient bits, so it ends as the quotient magnitude.
  logic [DW-1:0]    dq_q, dq_d;
  logic [WIDTH:0]   rem_q, rem_d;
  // WIDTH+1 bits so that |-2^(WIDTH-1)| is representable.
  logic [WIDTH:0]   dsr_q, dsr_d;
  logic             sign_q, sign_d;
  logic             dneg_q, dneg_d;
  logic             dvz_q, dvz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             signo_q, signo_d;
  logic             err_q, err_d;

  logic [DW-1:0]    dvd_abs;
  logic [WIDTH:0]   dsr_ext, dsr_abs;
  logic [WIDTH:0]   rem_shift;
  logic             ovf;

  always_comb begin
    dvd_abs   = dividend_i[DW-1] ? -dividend_i : dividend_i;
    dsr_ext   = {divisor_i[WIDTH-1], divisor_i};
    dsr_abs   = divisor_i[WIDTH-1] ? -dsr_ext : dsr_ext;
    rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, dq_q[DW-1]};
    // A negative result may reach one further than a positive one.
    ovf       = sign_q ? (dq_q > QMaxNeg) : (dq_q > QMaxPos);

    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    sign_d  = sign_q;
    dneg_d  = dneg_q;
    dvz_d   = dvz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    signo_d = signo_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start_i) begin
          dq_d    = dvd_abs;
          dsr_d   = dsr_abs;
          rem_d   = '0;
          cnt_d   = '0;
          sign_d  = dividend_i[DW-1] ^ divisor_i[WIDTH-1];
          dneg_d  = dividend_i[DW-1];
          dvz_d   = (divisor_i == '0);
          busy_d  = 1'b1;
          state_d = (divisor_i == '0) ? StFix : StDiv;
        end
      end
      StDiv: begin
        if (rem_shift >= dsr_q) begin
          rem_d = rem_shift - dsr_q;
          dq_d  = {dq_q[DW-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          dq_d  = {dq_q[DW-2:0], 1'b0};
        end
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFix: begin
        done_d  = 1'b1;
        signo_d = sign_q;
        state_d = StIdle;
        if (dvz_q || ovf) begin
          err_d  = 1'b1;
          remo_d = '0;
`ifdef DIVIDER_SATURATE_EN
          if (dvz_q) quot_d = dneg_q ? SatNeg : SatPos;
          else       quot_d = sign_q ? SatNeg : SatPos;
`else
          quot_d = '0;
`endif
        end else begin
          err_d  = 1'b0;
          quot_d = sign_q ? WIDTH'(-dq_q) : WIDTH'(dq_q);
          remo_d = dneg_q ? WIDTH'(-rem_q) : WIDTH'(rem_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      sign_q  <= 1'b0;
      dneg_q  <= 1'b0;
      dvz_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      signo_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      sign_q  <= sign_d;
      dneg_q  <= dneg_d;
      dvz_q   <= dvz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      signo_q <= signo_d;
      err_q   <= err_d;
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = remo_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign sign_o      = signo_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed edge cases, random
// operands against an integer-arithmetic reference, back-to-back operation,
// and reset during an operation.

module tb_seq_divider;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   dvd = '0;
  logic [7:0]    dsr = '0;
  logic [7:0]    quotient, remainder;
  logic          done, busy, sign, err;

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .dividend_i (dvd),
    .divisor_i  (dsr),
    .quotient_o (quotient),
    .remainder_o(remainder),
    .done_o     (done),
    .busy_o     (busy),
    .sign_o     (sign),
    .err_o      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer division, range-checked into 8 bits.
  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic e, output logic s);
    int sa, sb, qi, ri;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = a[15] ^ b[7];
    if (sb == 0) begin
      e = 1'b1;
      r = 8'h00;
`ifdef DIVIDER_SATURATE_EN
      q = (sa < 0) ? 8'h80 : 8'h7f;
`else
      q = 8'h00;
`endif
    end else begin
      qi = sa / sb;
      ri = sa % sb;
      if (qi > 127 || qi < -128) begin
        e = 1'b1;
        r = 8'h00;
`ifdef DIVIDER_SATURATE_EN
        q = (qi < 0) ? 8'h80 : 8'h7f;
`else
        q = 8'h00;
`endif
      end else begin
        e = 1'b0;
        q = qi[7:0];
        r = ri[7:0];
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b);
    logic [7:0] eq, er;
    logic       ee, es;
    model(a, b, eq, er, ee, es);
    check({tag, ".quot"}, 32'(quotient), 32'(eq));
    check({tag, ".rem"}, 32'(remainder), 32'(er));
    check({tag, ".err"}, 32'(err), 32'(ee));
    check({tag, ".sign"}, 32'(sign), 32'(es));
  endtask

  // One operation; operands are scrambled while busy, and with poke set a
  // stray start pulse is issued mid-operation.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input string tag,
                        input bit poke);
    int lat;
    bit busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    dvd = a;
    dsr = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (!busy) busy_ok = 1'b0;
      dvd = 16'($urandom);
      dsr = 8'($urandom);
      start = (poke && n == 5);
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(lat), (b == 8'h00) ? 32'd1 : 32'd17);
    check({tag, ".busy_during"}, 32'(busy_ok), 32'd1);
    check({tag, ".busy_at_done"}, 32'(busy), 32'd1);
    check_result(tag, a, b);
    @(posedge clk);
    #1;
    check({tag, ".done_width"}, 32'(done), 32'd0);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
  endtask

  logic [15:0] da[7] = '{16'h0064, 16'hFF9C, 16'hFF9C, 16'hC000, 16'h3F80, 16'hC000, 16'h01F4};
  logic [7:0]  db[7] = '{8'h07, 8'h07, 8'hF9, 8'h80, 8'h80, 8'h7F, 8'h00};
  logic [15:0] ba[3] = '{16'd1234, 16'hF448, 16'h7FFF};
  logic [7:0]  bb[3] = '{8'hC8, 8'd77, 8'h7F};

  initial begin
    int cyc, last;
    bit seen;
    logic [15:0] ra;
    logic [7:0]  rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.quot", 32'(quotient), 32'd0);
    check("rst.rem", 32'(remainder), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.sign", 32'(sign), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    for (int i = 0; i < 7; i++) run_op(da[i], db[i], $sformatf("dir%0d", i), 1'b0);

    // Randomized: half fully random, half constructed to mostly fit
    for (int i = 0; i < 60; i++) begin
      rb = 8'($urandom);
      if (i % 2 == 0) begin
        ra = 16'($urandom);
      end else begin
        ra = 16'(($signed(8'($urandom)) * $signed(rb)) + int'($urandom_range(0, 127)));
      end
      run_op(ra, rb, $sformatf("rnd%0d", i), (i % 3 == 0));
    end

    // Back-to-back with start held high
    @(negedge clk);
    dvd = ba[0];
    dsr = bb[0];
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      check($sformatf("b2b%0d.seen", k), 32'(seen), 32'd1);
      check($sformatf("b2b%0d.spacing", k), 32'(cyc - last), (k == 0) ? 32'd17 : 32'd18);
      check_result($sformatf("b2b%0d", k), ba[k], bb[k]);
      last = cyc;
      if (k < 2) begin
        dvd = ba[k+1];
        dsr = bb[k+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    check("b2b.idle", 32'(busy), 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    dvd = 16'd100;
    dsr = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.quot", 32'(quotient), 32'd0);
    check("midrst.rem", 32'(remainder), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.sign", 32'(sign), 32'd0);
    check("midrst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("midrst.no_done", 32'(seen), 32'd0);
    run_op(16'd1000, 8'd3, "post_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
